// File: rtl/microsequencer_stack_if.sv
// microsequencer_stack_if: decode/status/microstore-load inputs and control/state outputs of the sequencer.
interface microsequencer_stack_if #(
  parameter int ADDR_W = 7,
  parameter int CW_W = 20,
  parameter int STACK_DEPTH = 4
);
  localparam int UW_W = 7 + CW_W + ADDR_W;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  logic [ADDR_W-1:0] dec_addr, ld_addr, state;
  logic moc, cond, ld_en, stack_err;
  logic [UW_W-1:0] ld_data;
  logic [CW_W-1:0] ctrl;
  logic [SP_W-1:0] sp;
  modport master (output dec_addr, moc, cond, ld_en, ld_addr, ld_data, input ctrl, state, sp, stack_err);
  modport slave (input dec_addr, moc, cond, ld_en, ld_addr, ld_data, output ctrl, state, sp, stack_err);
endinterface

// File: rtl/microsequencer_stack.sv
// microsequencer_stack: writable-microstore sequencer, one microinstruction per cycle.
// Define USEQ_RETURN_STACK_EN to build the CALL/RET return stack.
module microsequencer_stack #(
  parameter int ADDR_W = 7,
  parameter int CW_W = 20,
  parameter int STACK_DEPTH = 4,
  parameter int FETCH_ADDR = 1
) (
  input logic Clk,
  input logic reset,
  microsequencer_stack_if.slave bus
);
  localparam int UW_W = 7 + CW_W + ADDR_W;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);
  logic [UW_W-1:0] store [2**ADDR_W];
  logic [UW_W-1:0] uw;
  logic [ADDR_W-1:0] state, nxt, inc, cra, ret_addr;
  logic [3:0] n;
  logic [1:0] s;
  logic inv, sel, sts, call;
  assign n = uw[UW_W-1 -: 4];
  assign inv = uw[UW_W-5];
  assign s = uw[UW_W-6 -: 2];
  assign cra = uw[ADDR_W-1:0];
  assign sel = s[1] ? s[0] : (s[0] ? bus.cond : bus.moc);
  assign sts = inv ^ sel;
  assign inc = state + ADDR_W'(1);
  assign call = n == 4'd8 || (n == 4'd10 && sts);
  always_comb begin
    case (n)
      4'd0: nxt = bus.dec_addr;
      4'd1: nxt = FETCH;
      4'd2: nxt = cra;
      4'd4: nxt = sts ? bus.dec_addr : cra;
      4'd5: nxt = sts ? cra : FETCH;
      4'd6: nxt = sts ? bus.dec_addr : inc;
      4'd7: nxt = sts ? FETCH : cra;
      4'd8, 4'd10: nxt = call ? cra : inc;
      4'd9: nxt = ret_addr;
      default: nxt = inc;
    endcase
  end
  // The microword register reads the pre-write contents when ld_addr collides with next.
  always_ff @(posedge Clk) begin
    if (bus.ld_en) store[bus.ld_addr] <= bus.ld_data;
    if (reset) begin
      state <= '0;
      uw <= store[0];
    end else begin
      state <= nxt;
      uw <= store[nxt];
    end
  end
`ifdef USEQ_RETURN_STACK_EN
  localparam int SI_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [ADDR_W-1:0] stk [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic err, full, empty, ret;
  assign full = sp == SP_W'(STACK_DEPTH);
  assign empty = sp == '0;
  assign ret = n == 4'd9;
  assign ret_addr = empty ? FETCH : stk[SI_W'(sp - SP_W'(1))];
  always_ff @(posedge Clk) begin
    if (reset) begin
      sp <= '0;
      err <= 1'b0;
    end else begin
      if (call && !full) begin
        stk[SI_W'(sp)] <= inc;
        sp <= sp + SP_W'(1);
      end else if (ret && !empty) sp <= sp - SP_W'(1);
      if ((call && full) || (ret && empty)) err <= 1'b1;
    end
  end
  assign bus.sp = sp;
  assign bus.stack_err = err;
`else
  assign ret_addr = FETCH;
  assign bus.sp = SP_W'(0);
  assign bus.stack_err = 1'b0;
`endif
  assign bus.ctrl = uw[ADDR_W +: CW_W];
  assign bus.state = state;
endmodule
